pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage pipeline. It drives the write-enable and flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers from three hazard sources: load-use, redirects (ID jump, MEM branch) and data-memory wait states. It also holds saturating stall/flush performance counters and a sticky memory-timeout error.

---
 rtl/pipeline_ctrl_pkg.sv | 17 +
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 23 ++
 rtl/pipeline_hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipeline_ctrl_pkg;

  // Controller states: normal decode, frozen on a data-memory wait, fatal timeout.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FREEZE = 2'd1,
    ERROR  = 2'd2
  } ctrlState_t;

  // Width of a register index in the instruction encoding.
  localparam int REG_W = 5;

  // Register 0 is hard-wired to zero, so it never creates a dependency.
  localparam logic [REG_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and redirect statistics.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up on inc, sticking at all-ones; clear wins over inc.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer: turns load-use, redirect and data-memory
// wait hazards into write-enable/flush controls for the pipeline registers.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             mem_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_bubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic             mem_timeout
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  ctrlState_t        state;
  ctrlState_t        nextState;
  logic [WAIT_W-1:0] waitCnt;
  logic [WAIT_W-1:0] nextWait;
  logic              loadUse;
  logic              stallInc;
  logic              flushInc;

  // A load in EX feeding the instruction in ID; register 0 never counts.
  assign loadUse = ex_mem_read && (ex_rt != ZERO_REG) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // Prioritised decode of the hazard sources into controls and next state.
  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    mem_wb_bubble = 1'b0;
    nextState     = state;
    nextWait      = waitCnt;
    flushInc      = 1'b0;
    if (!reset) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
      {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_bubble} = 4'b1111;
    end else begin
      case (state)
        RUN: begin
          if (dmem_req && !dmem_ready) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
            mem_wb_bubble = 1'b1;
            nextState     = FREEZE;
            nextWait      = WAIT_W'(1);
          end else if (mem_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            flushInc     = 1'b1;
          end else if (id_jump) begin
            if_id_flush = 1'b1;
            flushInc    = 1'b1;
          end else if (loadUse) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        FREEZE: begin
          if (dmem_ready) begin
            nextState = RUN;
            nextWait  = '0;
          end else begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
            mem_wb_bubble = 1'b1;
            if (waitCnt == WAIT_W'(TIMEOUT_CYCLES)) begin
              nextState = ERROR;
            end else begin
              nextWait = waitCnt + WAIT_W'(1);
            end
          end
        end
        default: begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
          {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_bubble} = 4'b1111;
        end
      endcase
    end
  end

  // Stall statistics cover live operation only, not the terminal error state.
  assign stallInc    = reset && !pc_en && (state != ERROR);
  assign mem_timeout = (state == ERROR);

  // State and wait counter; reset drops straight back to RUN from anywhere.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RUN;
      waitCnt <= '0;
    end else begin
      state   <= nextState;
      waitCnt <= nextWait;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) stallCounter (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .inc   (stallInc),
    .count (stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_W)) flushCounter (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .inc   (flushInc),
    .count (flush_events)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl: one default
// instance and one short-timeout instance for the error path.
module tb_pipeline_hazard_ctrl;

  // Control word order: {pc,if_id,id_ex,ex_mem en, if_id,id_ex,ex_mem flush, bubble}
  localparam logic [7:0] C_RUN    = 8'hF0;
  localparam logic [7:0] C_FREEZE = 8'h01;
  localparam logic [7:0] C_BRANCH = 8'hFE;
  localparam logic [7:0] C_JUMP   = 8'hF8;
  localparam logic [7:0] C_LDUSE  = 8'h34;
  localparam logic [7:0] C_FORCED = 8'h0F;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        toReset = 1'b0;
  logic [4:0]  idRs = '0, idRt = '0, exRt = '0;
  logic        idUsesRt = 1'b0, idJump = 1'b0, exMemRead = 1'b0;
  logic        branchTaken = 1'b0, dmemReq = 1'b0, dmemReady = 1'b0;
  logic        toReq = 1'b0, toReady = 1'b0;

  logic        pcEn, ifIdEn, idExEn, exMemEn, ifIdFlush, idExFlush, exMemFlush, memWbBubble;
  logic [15:0] stallCycles, flushEvents;
  logic        memTimeout;
  logic        tPcEn, tIfIdEn, tIdExEn, tExMemEn, tIfIdFlush, tIdExFlush, tExMemFlush, tBubble;
  logic [15:0] tStallCycles, tFlushEvents;
  logic        tMemTimeout;
  logic [7:0]  ctrl, tCtrl;

  int vectorCount = 0;
  int missCount   = 0;

  assign ctrl  = {pcEn, ifIdEn, idExEn, exMemEn, ifIdFlush, idExFlush, exMemFlush, memWbBubble};
  assign tCtrl = {tPcEn, tIfIdEn, tIdExEn, tExMemEn, tIfIdFlush, tIdExFlush, tExMemFlush, tBubble};

  always #5 clock = ~clock;

  pipeline_hazard_ctrl dut (
    .clk(clock), .reset(reset),
    .id_rs(idRs), .id_rt(idRt), .id_uses_rt(idUsesRt), .id_jump(idJump),
    .ex_mem_read(exMemRead), .ex_rt(exRt), .mem_branch_taken(branchTaken),
    .dmem_req(dmemReq), .dmem_ready(dmemReady),
    .pc_en(pcEn), .if_id_en(ifIdEn), .id_ex_en(idExEn), .ex_mem_en(exMemEn),
    .if_id_flush(ifIdFlush), .id_ex_flush(idExFlush), .ex_mem_flush(exMemFlush),
    .mem_wb_bubble(memWbBubble), .stall_cycles(stallCycles),
    .flush_events(flushEvents), .mem_timeout(memTimeout)
  );

  pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(16)) dutTo (
    .clk(clock), .reset(toReset),
    .id_rs(idRs), .id_rt(idRt), .id_uses_rt(idUsesRt), .id_jump(idJump),
    .ex_mem_read(exMemRead), .ex_rt(exRt), .mem_branch_taken(branchTaken),
    .dmem_req(toReq), .dmem_ready(toReady),
    .pc_en(tPcEn), .if_id_en(tIfIdEn), .id_ex_en(tIdExEn), .ex_mem_en(tExMemEn),
    .if_id_flush(tIfIdFlush), .id_ex_flush(tIdExFlush), .ex_mem_flush(tExMemFlush),
    .mem_wb_bubble(tBubble), .stall_cycles(tStallCycles),
    .flush_events(tFlushEvents), .mem_timeout(tMemTimeout)
  );

  // Counts one comparison and reports it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drives the hazard inputs of the main instance in one go.
  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                               input logic jump, input logic memRead, input logic [4:0] eRt,
                               input logic branch, input logic req, input logic ready);
    idRs = rs; idRt = rt; idUsesRt = usesRt; idJump = jump; exMemRead = memRead;
    exRt = eRt; branchTaken = branch; dmemReq = req; dmemReady = ready;
  endtask

  // Moves to just after the next rising edge.
  task automatic nextCycle;
    @(posedge clock);
    #1;
  endtask

  initial begin
    applyStimulus(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0);
    #2;
    checkOutput("resetCtrl", ctrl, C_FORCED);
    checkOutput("resetStall", stallCycles, 16'd0);
    checkOutput("resetFlush", flushEvents, 16'd0);
    checkOutput("resetTimeout", memTimeout, 1'b0);
    #10 reset = 1'b1;
    nextCycle();

    checkOutput("idle", ctrl, C_RUN);

    applyStimulus(5'd8, 5'd0, 0, 0, 1, 5'd8, 0, 0, 0);
    #1 checkOutput("loadUseRs", ctrl, C_LDUSE);
    nextCycle();
    applyStimulus(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0);
    #1 checkOutput("loadUseCleared", ctrl, C_RUN);
    checkOutput("stallAfterLoadUse", stallCycles, 16'd1);

    applyStimulus(5'd0, 5'd0, 0, 0, 1, 5'd0, 0, 0, 0);
    #1 checkOutput("loadR0NoStall", ctrl, C_RUN);
    nextCycle();
    checkOutput("stallAfterR0", stallCycles, 16'd1);

    applyStimulus(5'd3, 5'd9, 1, 0, 1, 5'd9, 0, 0, 0);
    #1 checkOutput("loadUseRt", ctrl, C_LDUSE);
    nextCycle();
    applyStimulus(5'd3, 5'd9, 0, 0, 1, 5'd9, 0, 0, 0);
    #1 checkOutput("rtNotUsed", ctrl, C_RUN);
    checkOutput("stallAfterRt", stallCycles, 16'd2);

    applyStimulus(5'd8, 5'd0, 0, 1, 1, 5'd8, 1, 0, 0);
    #1 checkOutput("branchBeatsLoadUse", ctrl, C_BRANCH);
    nextCycle();
    checkOutput("flushAfterBranch", flushEvents, 16'd1);
    checkOutput("stallAfterBranch", stallCycles, 16'd2);

    applyStimulus(5'd0, 5'd0, 0, 1, 0, 5'd0, 0, 0, 0);
    #1 checkOutput("jump", ctrl, C_JUMP);
    nextCycle();
    checkOutput("flushAfterJump", flushEvents, 16'd2);

    applyStimulus(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
    #1 checkOutput("freezeEnter", ctrl, C_FREEZE);
    nextCycle();
    applyStimulus(5'd0, 5'd0, 0, 1, 0, 5'd0, 0, 1, 0);
    #1 checkOutput("freezeJumpIgnored", ctrl, C_FREEZE);
    nextCycle();
    applyStimulus(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
    #1 checkOutput("freezeThird", ctrl, C_FREEZE);
    nextCycle();
    applyStimulus(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1);
    #1 checkOutput("freezeRelease", ctrl, C_RUN);
    nextCycle();
    applyStimulus(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0);
    #1 checkOutput("backToRun", ctrl, C_RUN);
    checkOutput("stallAfterFreeze", stallCycles, 16'd5);
    checkOutput("flushAfterFreeze", flushEvents, 16'd2);

    applyStimulus(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1);
    #1 checkOutput("reqReadySameCycle", ctrl, C_RUN);
    nextCycle();
    applyStimulus(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0);
    #1 checkOutput("reqReadyNoFreeze", ctrl, C_RUN);
    checkOutput("stallReqReady", stallCycles, 16'd5);

    applyStimulus(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
    nextCycle();
    #1 checkOutput("frozenBeforeReset", ctrl, C_FREEZE);
    reset = 1'b0;
    #1 checkOutput("asyncResetCtrl", ctrl, C_FORCED);
    checkOutput("asyncResetStall", stallCycles, 16'd0);
    checkOutput("asyncResetFlush", flushEvents, 16'd0);
    applyStimulus(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0);
    #1 reset = 1'b1;
    nextCycle();
    #1 checkOutput("runAfterReset", ctrl, C_RUN);

    toReset = 1'b1;
    toReq = 1'b1;
    toReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 checkOutput($sformatf("toFrozen%0d", i), tCtrl, C_FREEZE);
      nextCycle();
    end
    #1 checkOutput("toErrorCtrl", tCtrl, C_FORCED);
    checkOutput("toErrorFlag", tMemTimeout, 1'b1);
    checkOutput("toStall", tStallCycles, 16'd5);
    toReq = 1'b0;
    toReady = 1'b1;
    nextCycle();
    nextCycle();
    #1 checkOutput("toErrorSticky", tMemTimeout, 1'b1);
    checkOutput("toErrorStickyCtrl", tCtrl, C_FORCED);
    toReset = 1'b0;
    #1 checkOutput("toResetClears", tMemTimeout, 1'b0);
    toReady = 1'b0;
    #1 toReset = 1'b1;
    nextCycle();
    #1 checkOutput("toRunAfterReset", tCtrl, C_RUN);

    applyStimulus(5'd8, 5'd0, 0, 0, 1, 5'd8, 0, 0, 0);
    repeat (65534) nextCycle();
    checkOutput("stallNearMax", stallCycles, 16'hFFFE);
    nextCycle();
    checkOutput("stallAtMax", stallCycles, 16'hFFFF);
    nextCycle();
    checkOutput("stallSaturated", stallCycles, 16'hFFFF);
    checkOutput("stallHeldCtrl", ctrl, C_LDUSE);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
